// File: rtl/conv1d_pkg.sv
// Shared widths, requant configuration record and the rounding doubling
// high-multiply used by the conv1d requantise/pack datapath.
package conv1d_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int LANES   = 4;
  localparam int LCNT_W  = $clog2(LANES);
  localparam int COUNT_W = 3;

  typedef struct packed {
    logic signed [ACC_W-1:0] mult;
    logic        [4:0]       shift;
    logic signed [ACC_W-1:0] offset;
    logic signed [OUT_W-1:0] act_min;
    logic signed [OUT_W-1:0] act_max;
  } requant_cfg_t;

  // Unity-ish gain (x0.5 after the doubling high multiply), no shift, full int8 range.
  localparam requant_cfg_t CFG_RESET = '{
    mult:    32'h4000_0000,
    shift:   5'd0,
    offset:  32'h0000_0000,
    act_min: 8'h80,
    act_max: 8'h7F
  };

  localparam logic signed [ACC_W-1:0]   ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]   ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [2*ACC_W-1:0] RND_HALF = {{(ACC_W+1){1'b0}}, 1'b1, {(ACC_W-2){1'b0}}};

  // (a*b + 2^30) >>> 31 on a 64-bit signed product. The only input pair whose
  // result leaves the 32-bit range is MIN*MIN, which saturates to MAX.
  function automatic logic signed [ACC_W-1:0] rdh_mul(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [2*ACC_W-1:0] prod;
    logic signed [ACC_W-1:0]   res;
    prod = (2*ACC_W)'(a) * (2*ACC_W)'(b);
    prod = prod + RND_HALF;
    prod = prod >>> (ACC_W-1);
    res  = prod[ACC_W-1:0];
    if (a == ACC_MIN && b == ACC_MIN) begin
      res = ACC_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv1d_requant_lane.sv
// Two-stage per-element requantiser: stage 1 does the high multiply, stage 2
// does the rounding shift, offset add and activation clamp. Both stages
// freeze while stall is high.
module conv1d_requant_lane
  import conv1d_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] in_acc,
  input  logic                    in_last,
  input  requant_cfg_t            cfg,
  output logic                    out_valid,
  output logic        [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
);

  logic                    s1_valid;
  logic                    s1_last;
  logic signed [ACC_W-1:0] s1_h;

  logic signed [ACC_W:0]   h_ext;
  logic signed [ACC_W:0]   rnd_add;
  logic signed [ACC_W:0]   r_shift;
  logic signed [ACC_W:0]   v_sum;
  logic signed [ACC_W:0]   min_ext;
  logic signed [ACC_W:0]   max_ext;
  logic signed [ACC_W:0]   clamped;

  // Stage 1: high multiply of the accepted accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_h     <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      s1_h     <= rdh_mul(in_acc, cfg.mult);
    end
  end

  // Rounding arithmetic shift, offset and clamp in 33-bit arithmetic; a
  // min above max collapses onto max because max is applied last.
  always_comb begin
    h_ext   = {s1_h[ACC_W-1], s1_h};
    rnd_add = '0;
    if (cfg.shift != 5'd0) begin
      rnd_add = (ACC_W+1)'(1) << (cfg.shift - 5'd1);
    end
    r_shift = (h_ext + rnd_add) >>> cfg.shift;
    v_sum   = r_shift + {cfg.offset[ACC_W-1], cfg.offset};
    min_ext = {{(ACC_W+1-OUT_W){cfg.act_min[OUT_W-1]}}, cfg.act_min};
    max_ext = {{(ACC_W+1-OUT_W){cfg.act_max[OUT_W-1]}}, cfg.act_max};
    clamped = v_sum;
    if (clamped < min_ext) begin
      clamped = min_ext;
    end
    if (clamped > max_ext) begin
      clamped = max_ext;
    end
  end

  // Stage 2: register the int8 result with its row-end marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      out_last  <= s1_last;
      out_data  <= clamped[OUT_W-1:0];
    end
  end

  assign busy = s1_valid | out_valid;

endmodule

// File: rtl/conv1d_requant_pack.sv
// Requantises conv1d accumulators to int8 and packs four lanes per 32-bit
// word for the CFU response path. A row end flushes a partial word.
module conv1d_requant_pack
  import conv1d_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   in_acc,
  input  logic                      in_last,
  input  logic                      cfg_load,
  input  logic        [ACC_W-1:0]   cfg_mult,
  input  logic        [4:0]         cfg_shift,
  input  logic signed [ACC_W-1:0]   cfg_offset,
  input  logic signed [OUT_W-1:0]   cfg_act_min,
  input  logic signed [OUT_W-1:0]   cfg_act_max,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic [COUNT_W-1:0]        out_count,
  output logic                      idle
);

  requant_cfg_t             cfg_q;
  logic                     stall;
  logic                     accept;
  logic                     lane_valid;
  logic [OUT_W-1:0]         lane_q;
  logic                     lane_last;
  logic                     lane_busy;
  logic [LCNT_W-1:0]        lane_cnt;
  logic [LANES*OUT_W-1:0]   pack_data;
  logic [LANES*OUT_W-1:0]   merged;
  logic                     word_done;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Config capture; software only loads while the datapath is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q <= CFG_RESET;
    end else if (cfg_load) begin
      cfg_q.mult    <= cfg_mult;
      cfg_q.shift   <= cfg_shift;
      cfg_q.offset  <= cfg_offset;
      cfg_q.act_min <= cfg_act_min;
      cfg_q.act_max <= cfg_act_max;
    end
  end

  conv1d_requant_lane u_lane (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .in_valid  (accept),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .cfg       (cfg_q),
    .out_valid (lane_valid),
    .out_data  (lane_q),
    .out_last  (lane_last),
    .busy      (lane_busy)
  );

  // Drop the arriving result into its lane and decide whether the word closes.
  always_comb begin
    merged = pack_data;
    for (int i = 0; i < LANES; i++) begin
      if (int'(lane_cnt) == i) begin
        merged[i*OUT_W +: OUT_W] = lane_q;
      end
    end
    word_done = lane_valid & ((int'(lane_cnt) == LANES-1) | lane_last);
  end

  // Packer: accumulate lanes, restart at lane 0 in the same cycle a word leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_data <= '0;
      lane_cnt  <= '0;
    end else if (!stall && lane_valid) begin
      if (word_done) begin
        pack_data <= '0;
        lane_cnt  <= '0;
      end else begin
        pack_data <= merged;
        lane_cnt  <= lane_cnt + 1'b1;
      end
    end
  end

  // Output register: holds the word until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (!stall) begin
      out_valid <= word_done;
      if (word_done) begin
        out_data  <= merged;
        out_count <= {{(COUNT_W-LCNT_W){1'b0}}, lane_cnt} + 1'b1;
      end
    end
  end

  assign idle = ~lane_busy & (lane_cnt == '0) & ~out_valid;

endmodule

// File: tb/tb_conv1d_requant_pack.sv
// Directed bench for conv1d_requant_pack: inputs change at negedge+2, the
// bench reads at negedge+3 and the word monitor samples at negedge+4.
module tb_conv1d_requant_pack;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_acc;
  logic               in_last;
  logic               cfg_load;
  logic [31:0]        cfg_mult;
  logic [4:0]         cfg_shift;
  logic signed [31:0] cfg_offset;
  logic signed [7:0]  cfg_act_min;
  logic signed [7:0]  cfg_act_max;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [2:0]         out_count;
  logic               idle;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [34:0] wq[$];
  int          cq[$];

  int stall_acc[8] = '{10, 20, 30, 40, 50, -60, 70, 300};

  conv1d_requant_pack dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_acc      (in_acc),
    .in_last     (in_last),
    .cfg_load    (cfg_load),
    .cfg_mult    (cfg_mult),
    .cfg_shift   (cfg_shift),
    .cfg_offset  (cfg_offset),
    .cfg_act_min (cfg_act_min),
    .cfg_act_max (cfg_act_max),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word transferred on the output handshake.
  always @(negedge clk) begin
    #4;
    if (reset_n && out_valid && out_ready) begin
      wq.push_back({out_count, out_data});
      cq.push_back(cyc);
    end
  end

  task automatic send_elem(input logic [31:0] acc, input logic last);
    int g = 0;
    @(negedge clk); #2;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    #1;
    while (!in_ready && g < 50) begin
      @(negedge clk); #3;
      g++;
    end
  endtask

  task automatic drop_inputs();
    @(negedge clk); #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] m, input logic [4:0] s, input logic [31:0] o,
                          input logic [7:0] mn, input logic [7:0] mx);
    @(negedge clk); #2;
    cfg_mult = m; cfg_shift = s; cfg_offset = o; cfg_act_min = mn; cfg_act_max = mx;
    cfg_load = 1'b1;
    @(negedge clk); #2;
    cfg_load = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int g = 0;
    while (wq.size() < n && g < 60) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_vec++; if (out_count !== 3'd0) begin n_err++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle); end
    @(negedge clk); #2;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int acc_cyc;
    logic [34:0] got;
    wq.delete(); cq.delete();
    out_ready = 1'b1;
    send_elem(32'd100, 1'b0);
    send_elem(32'd200, 1'b0);
    send_elem(-32'sd100, 1'b0);
    send_elem(32'd1000, 1'b1);
    acc_cyc = cyc;
    drop_inputs();
    wait_words(1);
    got = (wq.size() > 0) ? wq[0] : 35'h0;
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL basic_word_count: got %0d expected 1", wq.size()); end
    n_vec++; if (got[31:0] !== 32'h7FCE6432) begin n_err++; $display("FAIL basic_data: got %h expected 7fce6432", got[31:0]); end
    n_vec++; if (got[34:32] !== 3'd4) begin n_err++; $display("FAIL basic_count: got %0d expected 4", got[34:32]); end
    n_vec++; if (cq.size() == 0 || cq[0] - acc_cyc != 3) begin n_err++; $display("FAIL basic_latency: got %0d expected 3", (cq.size() > 0) ? cq[0] - acc_cyc : -1); end
    #3;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL basic_idle_after: got %b expected 1", idle); end
  endtask

  task automatic test_shift_offset();
    logic [34:0] got;
    wq.delete(); cq.delete();
    load_cfg(32'h4000_0000, 5'd2, -32'sd3, 8'h80, 8'h7F);
    send_elem(32'd100, 1'b1);
    drop_inputs();
    wait_words(1);
    got = (wq.size() > 0) ? wq[0] : 35'h0;
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL shift_word_count: got %0d expected 1", wq.size()); end
    n_vec++; if (got[31:0] !== 32'h0000000A) begin n_err++; $display("FAIL shift_data: got %h expected 0000000a", got[31:0]); end
    n_vec++; if (got[34:32] !== 3'd1) begin n_err++; $display("FAIL shift_count: got %0d expected 1", got[34:32]); end
  endtask

  task automatic test_saturate_clamp();
    logic [34:0] got;
    wq.delete(); cq.delete();
    load_cfg(32'h8000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
    send_elem(32'h8000_0000, 1'b0);
    send_elem(32'h7FFF_FFFF, 1'b1);
    drop_inputs();
    wait_words(1);
    got = (wq.size() > 0) ? wq[0] : 35'h0;
    n_vec++; if (got[31:0] !== 32'h0000807F) begin n_err++; $display("FAIL saturate_data: got %h expected 0000807f", got[31:0]); end
    n_vec++; if (got[34:32] !== 3'd2) begin n_err++; $display("FAIL saturate_count: got %0d expected 2", got[34:32]); end
    // min above max: 50 and -50 both end up at max (5)
    wq.delete(); cq.delete();
    load_cfg(32'h4000_0000, 5'd0, 32'h0, 8'd10, 8'd5);
    send_elem(32'd100, 1'b0);
    send_elem(-32'sd100, 1'b1);
    drop_inputs();
    wait_words(1);
    got = (wq.size() > 0) ? wq[0] : 35'h0;
    n_vec++; if (got[31:0] !== 32'h00000505) begin n_err++; $display("FAIL minmax_data: got %h expected 00000505", got[31:0]); end
    n_vec++; if (got[34:32] !== 3'd2) begin n_err++; $display("FAIL minmax_count: got %0d expected 2", got[34:32]); end
    load_cfg(32'h4000_0000, 5'd0, 32'h0, 8'h80, 8'h7F);
  endtask

  task automatic test_stall();
    int fed = 0;
    int stall_left = 0;
    int stall_seen = 0;
    int g = 0;
    logic [34:0] held = '0;
    logic [34:0] w0;
    logic [34:0] w1;
    wq.delete(); cq.delete();
    out_ready = 1'b1;
    while ((fed < 8 || wq.size() < 2) && g < 200) begin
      @(negedge clk); #2;
      g++;
      if (out_valid && stall_seen == 0) begin
        stall_seen = 1;
        stall_left = 5;
        held = {out_count, out_data};
      end
      out_ready = (stall_left == 0);
      in_valid  = (fed < 8);
      if (fed < 8) begin
        in_acc  = stall_acc[fed];
        in_last = (fed == 3 || fed == 7);
      end else begin
        in_last = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        n_vec++; if ({out_count, out_data} !== held) begin n_err++; $display("FAIL stall_hold: got %h expected %h", {out_count, out_data}, held); end
        stall_left--;
      end
      if (in_valid && in_ready) fed++;
    end
    drop_inputs();
    wait_words(3);
    w0 = (wq.size() > 0) ? wq[0] : 35'h0;
    w1 = (wq.size() > 1) ? wq[1] : 35'h0;
    n_vec++; if (stall_seen != 1) begin n_err++; $display("FAIL stall_seen: got %0d expected 1", stall_seen); end
    n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL stall_word_count: got %0d expected 2", wq.size()); end
    n_vec++; if (w0 !== {3'd4, 32'h140F0A05}) begin n_err++; $display("FAIL stall_word0: got %h expected 4_140f0a05", w0); end
    n_vec++; if (w1 !== {3'd4, 32'h7F23E219}) begin n_err++; $display("FAIL stall_word1: got %h expected 4_7f23e219", w1); end
    n_vec++; if (held !== {3'd4, 32'h140F0A05}) begin n_err++; $display("FAIL stall_held_word: got %h expected 4_140f0a05", held); end
  endtask

  task automatic test_reset_mid();
    logic [34:0] got;
    wq.delete(); cq.delete();
    out_ready = 1'b1;
    send_elem(32'd10, 1'b0);
    send_elem(32'd20, 1'b0);
    drop_inputs();
    repeat (3) @(negedge clk);
    #3;
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL midreset_busy_before: got %b expected 0", idle); end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL midreset_idle: got %b expected 1", idle); end
    @(negedge clk); #2;
    reset_n = 1'b1;
    send_elem(32'd100, 1'b1);
    drop_inputs();
    wait_words(1);
    got = (wq.size() > 0) ? wq[0] : 35'h0;
    n_vec++; if (wq.size() != 1) begin n_err++; $display("FAIL midreset_word_count: got %0d expected 1", wq.size()); end
    n_vec++; if (got !== {3'd1, 32'h00000032}) begin n_err++; $display("FAIL midreset_word: got %h expected 1_00000032", got); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] got;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h04030201;
    exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09;
    wq.delete(); cq.delete();
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      send_elem(32'(2 * k), (k % 4) == 0);
    end
    drop_inputs();
    wait_words(3);
    n_vec++; if (wq.size() != 3) begin n_err++; $display("FAIL b2b_word_count: got %0d expected 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (wq.size() > i) ? wq[i] : 35'h0;
      n_vec++; if (got !== {3'd4, exp_w[i]}) begin n_err++; $display("FAIL b2b_word%0d: got %h expected 4_%h", i, got, exp_w[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_vec++;
      if (cq.size() <= i || cq[i] - cq[i-1] != 4) begin
        n_err++;
        $display("FAIL b2b_spacing%0d: got %0d expected 4", i, (cq.size() > i) ? cq[i] - cq[i-1] : -1);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_acc      = '0;
    in_last     = 1'b0;
    cfg_load    = 1'b0;
    cfg_mult    = 32'h4000_0000;
    cfg_shift   = 5'd0;
    cfg_offset  = '0;
    cfg_act_min = 8'h80;
    cfg_act_max = 8'h7F;
    out_ready   = 1'b1;
    test_reset();
    test_basic();
    test_shift_offset();
    test_saturate_clamp();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv1d_requant_pack.md
CONV1D_REQUANT_PACK -- requirements
Module: conv1d_requant_pack

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1 / in_ready  out  1  handshake for accumulator input, from the conv1d engine.
REQ-004 SHALL have: in_acc  in  32  signed conv1d accumulator / in_last  in  1  marks final element of a row.
REQ-005 SHALL have: cfg_load  in  1 / cfg_mult  in  32 / cfg_shift  in  5 / cfg_offset  in  32 signed / cfg_act_min  in  8 signed / cfg_act_max  in  8 signed  requant config.
REQ-006 SHALL have: out_valid  out  1 / out_ready  in  1  handshake for packed result to the CFU response path.
REQ-007 SHALL have: out_data  out  32  four int8 lanes, lane 0 in [7:0] / out_count  out  3  valid lanes, 1..4.
REQ-008 SHALL have: idle  out  1  high when no element is in the pipeline, packer or output register.

Function
REQ-009 Transfer SHALL occur on in_valid&in_ready or out_valid&out_ready at a rising clk edge.
REQ-010 stall = out_valid & ~out_ready; in_ready SHALL equal ~stall, and all stages SHALL hold while stall.
REQ-011 cfg_load SHALL capture all cfg_* into config registers; it is legal only when idle=1, and the design need not protect against loads when idle=0.
REQ-012 Stage 1 SHALL compute the rounding doubling high multiply h = (in_acc*cfg_mult + 2^30) >>> 31, using a 64-bit signed product.
REQ-013 If in_acc = cfg_mult = 0x80000000, h SHALL saturate to 0x7FFFFFFF.
REQ-014 Stage 2 SHALL compute r = (h + (cfg_shift ? 2^(cfg_shift-1) : 0)) >>> cfg_shift as an arithmetic shift, then v = r + cfg_offset in 33-bit arithmetic, then clamp v to [cfg_act_min, cfg_act_max].
REQ-015 Element-to-packer latency SHALL be 2 cycles when not stalled; in_last SHALL travel with its element.
REQ-016 The packer SHALL place successive results in lanes 0..3; unused lanes SHALL be 0.
REQ-017 When lane 3 is filled or an element with in_last is placed, the word SHALL move to the output register and set out_valid next cycle, with out_count equal to the number of filled lanes.
REQ-018 A new element SHALL begin the next word in the same cycle the previous word moves out; there SHALL be no bubble.
REQ-019 out_data and out_count SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Input is not accepted when in_valid=0, so no partial word SHALL ever be emitted without in_last.
REQ-021 If cfg_act_min > cfg_act_max, the output SHALL equal cfg_act_max; clamp order is min first, then max.

Reset
REQ-022 When reset_n=0, all valid flags, the lane counter and the packer contents SHALL clear immediately; a partial word SHALL be discarded.
REQ-023 Reset values SHALL be: out_valid=0, out_data=0, out_count=0, in_ready=1, idle=1.
REQ-024 Config registers SHALL reset to mult=0x40000000, shift=0, offset=0, min=-128, max=127.
REQ-025 Reset release mid-operation SHALL need no flush; the first accepted element after release starts at lane 0.

Structure
REQ-026 Package conv1d_pkg SHALL hold ACC_W=32, OUT_W=8, LANES=4 and a packed struct requant_cfg_t with the five config fields.
REQ-027 Per-element arithmetic SHALL be a sub-module conv1d_requant_lane implementing the 2-stage multiply/shift/offset/clamp path with a stall input.
REQ-028 Packer, lane counter and output register SHALL reside in the top module.

Verification
REQ-029 Reset config, out_ready=1, in_acc = 100, 200, -100, 1000 (last on 4th) -> one word out_data=0x7FCE6432, out_count=4.
REQ-030 cfg shift=2, offset=-3; in_acc=100 with in_last -> out_data=0x0000000A, out_count=1.
REQ-031 cfg mult=0x80000000; in_acc=0x80000000 with in_last -> lane0=0x7F (saturated, clamped).
REQ-032 Stream 8 elements with out_ready held 0 for 5 cycles after the first word -> in_ready=0 during the stall, word held stable, both words correct, no element lost or duplicated.
REQ-033 Feed 2 elements, then assert reset_n=0 before in_last -> out_valid=0 and idle=1 at once; a following single-element row starts at lane 0.
REQ-034 Back-to-back rows of 4 with out_ready=1 -> one word every 4 cycles, no bubbles.
